mcb_port_responder: RTL

//  Synthesizable responder for one Spartan-6 MCB user port (c3_p0_*). It accepts cmd/wr/rd FIFO traffic and backs it with on-chip byte-writable RAM.

---
 rtl/mcb_resp_pkg.sv | 39 +++
 rtl/mcb_port_responder_if.sv | 40 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mcb_port_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mcb_resp_pkg.sv
// Shared types and encodings for the MCB user-port responder.
// Command layout, FSM states and instruction decode helpers live here.
package mcb_resp_pkg;

  localparam int DATA_W  = 64;
  localparam int MASK_W  = 8;
  localparam int BL_W    = 6;
  localparam int ADDR_W  = 30;
  localparam int INSTR_W = 3;
  localparam int CNT_W   = 7;
  localparam int CMD_W   = INSTR_W + BL_W + ADDR_W;

  localparam logic [INSTR_W-1:0] INSTR_WR    = 3'b000;
  localparam logic [INSTR_W-1:0] INSTR_RD    = 3'b001;
  localparam logic [INSTR_W-1:0] INSTR_WR_AP = 3'b010;
  localparam logic [INSTR_W-1:0] INSTR_RD_AP = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_READ
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [BL_W-1:0]    bl;
    logic [ADDR_W-1:0]  addr;
  } cmd_t;

  function automatic logic is_write(input logic [INSTR_W-1:0] instr);
    return (instr == INSTR_WR) || (instr == INSTR_WR_AP);
  endfunction

  function automatic logic is_read(input logic [INSTR_W-1:0] instr);
    return (instr == INSTR_RD) || (instr == INSTR_RD_AP);
  endfunction

endpackage

// File: rtl/mcb_port_responder_if.sv
// One MCB user port (cmd/wr/rd FIFO signals), named as the c3_p0_* port without prefix.
interface mcb_port_responder_if;
  import mcb_resp_pkg::*;

  logic               cmd_en;
  logic [INSTR_W-1:0] cmd_instr;
  logic [BL_W-1:0]    cmd_bl;
  logic [ADDR_W-1:0]  cmd_byte_addr;
  logic               cmd_full;
  logic               cmd_empty;

  logic               wr_en;
  logic [DATA_W-1:0]  wr_data;
  logic [MASK_W-1:0]  wr_mask;
  logic               wr_full;
  logic               wr_empty;
  logic [CNT_W-1:0]   wr_count;
  logic               wr_underrun;
  logic               wr_error;

  logic               rd_en;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_full;
  logic               rd_empty;
  logic [CNT_W-1:0]   rd_count;
  logic               rd_error;

  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask, rd_en,
    input  cmd_full, cmd_empty, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    input  rd_data, rd_full, rd_empty, rd_count, rd_error
  );

  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_data, wr_mask, rd_en,
    output cmd_full, cmd_empty, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
    output rd_data, rd_full, rd_empty, rd_count, rd_error
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; with FWFT the head word is visible on dout while not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4,
  parameter bit FWFT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign full      = count[AW];
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign overflow  = push && !push_ok;
  assign underflow = pop && !pop_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // NOTE: storage arrays carry no reset; flushing the pointers empties the FIFO
  // and keeps the array mappable onto RAM primitives.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

  if (FWFT) begin : g_fwft
    assign dout = mem[rptr];
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      dout <= '0;
      else if (pop_ok) dout <= mem[rptr];
    end
  end

endmodule

// File: rtl/mcb_port_responder.sv
// Emulates one Spartan-6 MCB user port backed by on-chip byte-writable RAM:
// queued commands run in order, one data word per cycle, after emulated calibration.
module mcb_port_responder
  import mcb_resp_pkg::*;
#(
  parameter int MEM_AW       = 10,
  parameter int FIFO_AW      = 6,
  parameter int CMD_AW       = 2,
  parameter int CALIB_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 c3_calib_done,
  mcb_port_responder_if.slave  c3_p0
);

  localparam int CAL_W    = $clog2(CALIB_CYCLES + 1);
  localparam int RD_DEPTH = 2**FIFO_AW;

  logic [CAL_W-1:0] calib_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      calib_cnt     <= '0;
      c3_calib_done <= 1'b0;
    end else if (!c3_calib_done) begin
      calib_cnt     <= calib_cnt + 1'b1;
      c3_calib_done <= (calib_cnt == CAL_W'(CALIB_CYCLES - 1));
    end
  end

  cmd_t             cmd_in;
  cmd_t             cmd_head;
  logic             cmd_pop;
  logic             cmd_fifo_empty;
  logic [CMD_AW:0]  cmd_count;
  logic             cmd_overflow;
  logic             cmd_underflow;

  assign cmd_in = {c3_p0.cmd_instr, c3_p0.cmd_bl, c3_p0.cmd_byte_addr};

  sync_fifo #(.WIDTH(CMD_W), .AW(CMD_AW), .FWFT(1'b1)) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (c3_p0.cmd_en),
    .din       (cmd_in),
    .pop       (cmd_pop),
    .dout      (cmd_head),
    .full      (c3_p0.cmd_full),
    .empty     (cmd_fifo_empty),
    .count     (cmd_count),
    .overflow  (cmd_overflow),
    .underflow (cmd_underflow)
  );

  logic [DATA_W+MASK_W-1:0] wr_head;
  logic [DATA_W-1:0]        wr_word;
  logic [MASK_W-1:0]        wr_lane_mask;
  logic                     wr_pop;
  logic                     wr_fifo_empty;
  logic                     wr_overflow;
  logic                     wr_underflow;

  assign wr_word      = wr_head[DATA_W+MASK_W-1:MASK_W];
  assign wr_lane_mask = wr_head[MASK_W-1:0];

  sync_fifo #(.WIDTH(DATA_W+MASK_W), .AW(FIFO_AW), .FWFT(1'b1)) u_wr_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (c3_p0.wr_en),
    .din       ({c3_p0.wr_data, c3_p0.wr_mask}),
    .pop       (wr_pop),
    .dout      (wr_head),
    .full      (c3_p0.wr_full),
    .empty     (wr_fifo_empty),
    .count     (c3_p0.wr_count),
    .overflow  (wr_overflow),
    .underflow (wr_underflow)
  );

  logic [DATA_W-1:0] ram_q;
  logic              rd_pend;
  logic [FIFO_AW:0]  rd_count;
  logic [FIFO_AW:0]  rd_free;
  logic              rd_overflow;
  logic              rd_underflow;

  sync_fifo #(.WIDTH(DATA_W), .AW(FIFO_AW), .FWFT(1'b1)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (rd_pend),
    .din       (ram_q),
    .pop       (c3_p0.rd_en),
    .dout      (c3_p0.rd_data),
    .full      (c3_p0.rd_full),
    .empty     (c3_p0.rd_empty),
    .count     (rd_count),
    .overflow  (rd_overflow),
    .underflow (rd_underflow)
  );

  assign c3_p0.rd_count = rd_count;
  assign c3_p0.wr_empty = wr_fifo_empty;
  assign rd_free        = (FIFO_AW+1)'(RD_DEPTH) - rd_count;

  state_t            state, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [FIFO_AW:0]  rem_q, rem_d;
  logic              ram_we;
  logic              ram_re;
  logic              underrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      rd_pend <= 1'b0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      rd_pend <= ram_re;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    rem_d    = rem_q;
    cmd_pop  = 1'b0;
    wr_pop   = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    underrun = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (c3_calib_done && !cmd_fifo_empty) begin
          cmd_pop = 1'b1;
          addr_d  = cmd_head.addr[MEM_AW+2:3];
          rem_d   = (FIFO_AW+1)'(cmd_head.bl) + 1'b1;
          if (is_write(cmd_head.instr))     state_d = ST_WRITE;
          else if (is_read(cmd_head.instr)) state_d = ST_RD_WAIT;
        end
      end
      ST_WRITE: begin
        // An empty wr FIFO skips the slot rather than stalling the burst.
        if (wr_fifo_empty) begin
          underrun = 1'b1;
        end else begin
          wr_pop = 1'b1;
          ram_we = 1'b1;
        end
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == 1) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        // Issue only once the whole burst fits, so the rd FIFO can never overflow.
        if (rd_free >= rem_q) begin
          ram_re  = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == 1) ? ST_IDLE : ST_READ;
        end
      end
      ST_READ: begin
        ram_re = 1'b1;
        addr_d = addr_q + 1'b1;
        rem_d  = rem_q - 1'b1;
        if (rem_q == 1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [DATA_W-1:0] ram [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wr_lane_mask[b]) ram[addr_q][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
    if (ram_re) ram_q <= ram[addr_q];
  end

  logic wr_error_q;
  logic rd_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_error_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_error_q <= wr_error_q | underrun | wr_overflow;
      rd_error_q <= rd_error_q | rd_underflow;
    end
  end

  assign c3_p0.cmd_empty   = cmd_fifo_empty && (state == ST_IDLE);
  assign c3_p0.wr_underrun = underrun;
  assign c3_p0.wr_error    = wr_error_q;
  assign c3_p0.rd_error    = rd_error_q;

  logic unused_ok;
  assign unused_ok = ^{cmd_head.addr[ADDR_W-1:MEM_AW+3], cmd_head.addr[2:0], cmd_count,
                       cmd_overflow, cmd_underflow, rd_overflow, wr_underflow};

endmodule
